// File: rtl/eqn_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : eqn_pkg
//  Purpose  : Shared widths, default IP latencies and the operand triple type
//             for the (a+b)-((a/b)*c) equation datapath.
//  Revision : 1.0  initial release
// ============================================================================
package eqn_pkg;

    // IEEE-754 single precision word
    localparam int FP_W = 32;

    // Default latencies of the floating-point IP cores
    localparam int C_DEF_DIV_LAT    = 28;
    localparam int C_DEF_MUL_LAT    = 8;
    localparam int C_DEF_SUB_LAT    = 11;
    localparam int C_DEF_FIFO_DEPTH = 4;
    localparam int C_DEF_ID_W       = 8;

    // One operand triple as stored in the input FIFO (96 bits, a in the MSBs)
    typedef struct packed {
        logic [FP_W-1:0] a;
        logic [FP_W-1:0] b;
        logic [FP_W-1:0] c;
    } operand_t;

    // c must reach the multiplier together with the registered quotient
    function automatic int c_dly_of(input int div_lat);
        return div_lat + 1;
    endfunction

    // a/b issue -> equation result register
    function automatic int res_lat_of(input int div_lat, input int mul_lat,
                                      input int sub_lat);
        return div_lat + 1 + mul_lat + sub_lat + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/eqn_operand_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Interface : eqn_operand_sequencer_if
//  Purpose   : Operand intake handshake, issue control and the issue/result
//              strobes of the operand sequencer.
//  Revision  : 1.0  initial release
// ============================================================================
interface eqn_operand_sequencer_if #(
    parameter int ID_W = 8
);
    import eqn_pkg::*;

    // Operand intake
    logic                in_valid;
    logic                in_ready;
    logic [FP_W-1:0]     in_a;
    logic [FP_W-1:0]     in_b;
    logic [FP_W-1:0]     in_c;

    // Issue control
    logic                issue_en;

    // Towards adder / divider / multiplier
    logic [FP_W-1:0]     dataa;
    logic [FP_W-1:0]     datab;
    logic                validdataa;
    logic                validdatab;
    logic [FP_W-1:0]     datac;
    logic                validdatac;

    // Latency-matched result tag and status
    logic                result_valid;
    logic [ID_W-1:0]     result_id;
    logic                busy;

    // Producer / observer side
    modport master (
        output in_valid, in_a, in_b, in_c, issue_en,
        input  in_ready, dataa, datab, validdataa, validdatab,
        input  datac, validdatac, result_valid, result_id, busy
    );

    // Sequencer side
    modport slave (
        input  in_valid, in_a, in_b, in_c, issue_en,
        output in_ready, dataa, datab, validdataa, validdatab,
        output datac, validdatac, result_valid, result_id, busy
    );

endinterface
`default_nettype wire

// File: rtl/eqn_delay_line.sv
`default_nettype none
// ============================================================================
//  Module   : eqn_delay_line
//  Purpose  : Valid + data shift pipe, DEPTH stages. The output is the last
//             stage, so a sample appears DEPTH cycles after it is presented.
//  Revision : 1.0  initial release
// ============================================================================
module eqn_delay_line #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  wire logic         clock,
    input  wire logic         resetn,
    input  wire logic         in_valid,
    input  wire logic [W-1:0] in_data,
    output logic              out_valid,
    output logic [W-1:0]      out_data,
    output logic              any_valid
);

    logic [DEPTH-1:0]        r_valid;
    logic [DEPTH-1:0][W-1:0] r_data;

    // Shift valid and data one stage per cycle; reset clears every stage
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_valid <= '0;
            r_data  <= '0;
        end else begin
            r_valid[0] <= in_valid;
            r_data[0]  <= in_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_data[i]  <= r_data[i-1];
            end
        end
    end

    assign out_valid = r_valid[DEPTH-1];
    assign out_data  = r_data[DEPTH-1];

    // Something still travelling through the pipe
    assign any_valid = |r_valid;

endmodule
`default_nettype wire

// File: rtl/eqn_operand_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : eqn_operand_sequencer
//  Purpose  : Buffers (a,b,c) operand triples, issues a/b to the adder and
//             divider, issues c DIV_LAT+1 cycles later to meet the registered
//             quotient, and produces a latency-matched result tag.
//  Revision : 1.0  initial release
// ============================================================================
module eqn_operand_sequencer
    import eqn_pkg::*;
#(
    parameter int DIV_LAT    = C_DEF_DIV_LAT,
    parameter int MUL_LAT    = C_DEF_MUL_LAT,
    parameter int SUB_LAT    = C_DEF_SUB_LAT,
    parameter int FIFO_DEPTH = C_DEF_FIFO_DEPTH,
    parameter int ID_W       = C_DEF_ID_W
) (
    input  wire logic              clock,
    input  wire logic              resetn,
    eqn_operand_sequencer_if.slave bus
);

    localparam int C_DLY   = c_dly_of(DIV_LAT);
    localparam int RES_LAT = res_lat_of(DIV_LAT, MUL_LAT, SUB_LAT);
    localparam int AW      = $clog2(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Operand FIFO: pointers carry one extra wrap bit so that full and
    // empty are told apart by the MSB compare. No bypass in either
    // direction: a full FIFO refuses a write even while it is being
    // popped, and a freshly written entry is issuable one cycle later.
    // ------------------------------------------------------------------
    operand_t        r_mem [FIFO_DEPTH];
    logic [AW:0]     r_wr_ptr;
    logic [AW:0]     r_rd_ptr;
    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    operand_t        w_head;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push  = bus.in_valid && !w_full;
    assign w_pop   = bus.issue_en && !w_empty;
    assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

    assign bus.in_ready = !w_full;

    // Storage array, written on every accepted transfer
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= operand_t'({bus.in_a, bus.in_b, bus.in_c});
        end
    end

    // Read/write pointer update
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Issue stage: one pop per cycle while enabled. a/b hold their last
    // value between issues; c and the id are captured alongside and
    // enter their delay lines on the cycle validdataa is high.
    // ------------------------------------------------------------------
    logic [FP_W-1:0] r_dataa;
    logic [FP_W-1:0] r_datab;
    logic            r_valid_ab;
    logic [FP_W-1:0] r_c_issue;
    logic [ID_W-1:0] r_id_issue;
    logic [ID_W-1:0] r_id_cnt;

    // Register the issued triple and tag it with the running id
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_dataa    <= '0;
            r_datab    <= '0;
            r_valid_ab <= 1'b0;
            r_c_issue  <= '0;
            r_id_issue <= '0;
            r_id_cnt   <= '0;
        end else begin
            r_valid_ab <= w_pop;
            if (w_pop) begin
                r_dataa    <= w_head.a;
                r_datab    <= w_head.b;
                r_c_issue  <= w_head.c;
                r_id_issue <= r_id_cnt;
                r_id_cnt   <= r_id_cnt + ID_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // c path: fed from the issue registers, so datac lands exactly C_DLY
    // cycles after the matching validdataa.
    // ------------------------------------------------------------------
    logic            w_c_valid;
    logic [FP_W-1:0] w_c_data;
    logic            w_c_any;

    eqn_delay_line #(
        .W     (FP_W),
        .DEPTH (C_DLY)
    ) u_c_pipe (
        .clock     (clock),
        .resetn    (resetn),
        .in_valid  (r_valid_ab),
        .in_data   (r_c_issue),
        .out_valid (w_c_valid),
        .out_data  (w_c_data),
        .any_valid (w_c_any)
    );

    // ------------------------------------------------------------------
    // Result tag path: the id rides alongside the datapath and pops out
    // RES_LAT cycles after validdataa, when the result register is loaded.
    // ------------------------------------------------------------------
    logic            w_tag_valid;
    logic [ID_W-1:0] w_tag_id;
    logic            w_tag_any;

    eqn_delay_line #(
        .W     (ID_W),
        .DEPTH (RES_LAT)
    ) u_tag_pipe (
        .clock     (clock),
        .resetn    (resetn),
        .in_valid  (r_valid_ab),
        .in_data   (r_id_issue),
        .out_valid (w_tag_valid),
        .out_data  (w_tag_id),
        .any_valid (w_tag_any)
    );

    // ------------------------------------------------------------------
    // Outputs. The issue register counts as the first stage of both
    // pipes, so busy stays high continuously from push to retirement.
    // ------------------------------------------------------------------
    assign bus.dataa        = r_dataa;
    assign bus.datab        = r_datab;
    assign bus.validdataa   = r_valid_ab;
    assign bus.validdatab   = r_valid_ab;
    assign bus.datac        = w_c_data;
    assign bus.validdatac   = w_c_valid;
    assign bus.result_valid = w_tag_valid;
    assign bus.result_id    = w_tag_id;
    assign bus.busy         = !w_empty || r_valid_ab || w_c_any || w_tag_any;

endmodule
`default_nettype wire

// File: tb/tb_eqn_operand_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_eqn_operand_sequencer
//  Purpose  : Self-checking bench for eqn_operand_sequencer with a queue
//             scoreboard for issue order, c timing and result tags.
//  Revision : 1.0  initial release
// ============================================================================
module tb_eqn_operand_sequencer;
    import eqn_pkg::*;

    localparam int ID_W    = 8;
    localparam int C_DLY   = 29;   // 28 + 1
    localparam int RES_LAT = 49;   // 28 + 1 + 8 + 11 + 1

    logic clock  = 1'b0;
    logic resetn = 1'b0;

    eqn_operand_sequencer_if #(.ID_W(ID_W)) sif();

    eqn_operand_sequencer #(
        .DIV_LAT    (28),
        .MUL_LAT    (8),
        .SUB_LAT    (11),
        .FIFO_DEPTH (4),
        .ID_W       (ID_W)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (sif.slave)
    );

    always #5 clock = ~clock;

    typedef struct { logic [31:0] a; logic [31:0] b; logic [31:0] c; } trip_t;
    typedef struct { logic [31:0] c; int due; } cexp_t;
    typedef struct { logic [ID_W-1:0] id; int due; } rexp_t;

    trip_t q_in[$];
    cexp_t q_c[$];
    rexp_t q_res[$];

    int              n_checks = 0;
    int              n_errors = 0;
    int              ncyc     = 0;
    int              res_seen = 0;
    logic [ID_W-1:0] model_id    = '0;
    logic [ID_W-1:0] last_res_id = '0;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard: accepted triples are queued; each validdataa pops one and
    // schedules its c and result tag at fixed offsets from that cycle.
    task automatic scoreboard_monitor();
        trip_t t;
        forever begin
            @(negedge clock);
            ncyc++;
            if (!resetn) begin
                q_in.delete();
                q_c.delete();
                q_res.delete();
                model_id = '0;
            end else begin
                if (sif.validdataa) begin
                    n_checks++;
                    if (q_in.size() == 0) begin
                        n_errors++;
                        $display("FAIL sb_unexpected_issue: validdataa=1 with no pending triple (cycle %0d)", ncyc);
                    end else begin
                        t = q_in.pop_front();
                        if (sif.dataa !== t.a || sif.datab !== t.b || sif.validdatab !== 1'b1) begin
                            n_errors++;
                            $display("FAIL sb_issue_ab: got a=%h b=%h vb=%b expected a=%h b=%h vb=1",
                                     sif.dataa, sif.datab, sif.validdatab, t.a, t.b);
                        end
                        q_c.push_back('{c: t.c, due: ncyc + C_DLY});
                        q_res.push_back('{id: model_id, due: ncyc + RES_LAT});
                        model_id = model_id + 1'b1;
                    end
                end
                if (q_c.size() != 0 && q_c[0].due == ncyc) begin
                    n_checks++;
                    if (sif.validdatac !== 1'b1 || sif.datac !== q_c[0].c) begin
                        n_errors++;
                        $display("FAIL sb_c_issue: got vc=%b c=%h expected vc=1 c=%h",
                                 sif.validdatac, sif.datac, q_c[0].c);
                    end
                    void'(q_c.pop_front());
                end else if (sif.validdatac) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sb_c_unexpected: validdatac=1 got, 0 expected (cycle %0d)", ncyc);
                end
                if (q_res.size() != 0 && q_res[0].due == ncyc) begin
                    n_checks++;
                    if (sif.result_valid !== 1'b1 || sif.result_id !== q_res[0].id) begin
                        n_errors++;
                        $display("FAIL sb_result: got rv=%b id=%0d expected rv=1 id=%0d",
                                 sif.result_valid, sif.result_id, q_res[0].id);
                    end else begin
                        res_seen++;
                        last_res_id = sif.result_id;
                    end
                    void'(q_res.pop_front());
                end else if (sif.result_valid) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sb_result_unexpected: result_valid=1 id=%0d got, 0 expected", sif.result_id);
                end
                if (sif.in_valid && sif.in_ready) begin
                    q_in.push_back('{a: sif.in_a, b: sif.in_b, c: sif.in_c});
                end
            end
        end
    endtask

    // Present one triple and hold it until accepted; in_valid stays high
    task automatic drive_one(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        bit ok = 1'b0;
        sif.in_a     = a;
        sif.in_b     = b;
        sif.in_c     = c;
        sif.in_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clock);
            if (sif.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL push_timeout: in_ready got 0 for 50 cycles, expected 1");
        end
        tick();
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if (!sif.busy && q_in.size() == 0 && q_c.size() == 0 && q_res.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL idle_timeout: busy=%b pending in=%0d c=%0d res=%0d, expected all 0",
                     sif.busy, q_in.size(), q_c.size(), q_res.size());
        end
        tick();
    endtask

    task automatic do_reset();
        tick();
        resetn = 1'b0;
        repeat (3) tick();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        repeat (5) tick();
        @(negedge clock);
        n_checks++;
        if (sif.in_ready !== 1'b1 || sif.validdataa !== 1'b0 || sif.result_valid !== 1'b0 || sif.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_hold: got rdy=%b va=%b rv=%b busy=%b expected 1 0 0 0",
                     sif.in_ready, sif.validdataa, sif.result_valid, sif.busy);
        end
        tick();
        resetn = 1'b1;
        @(negedge clock);
        n_checks++;
        if (sif.in_ready !== 1'b1 || sif.validdatac !== 1'b0 || sif.dataa !== 32'h0 ||
            sif.datac !== 32'h0 || sif.result_id !== '0 || sif.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_release: got rdy=%b vc=%b a=%h c=%h id=%0d busy=%b expected 1 0 0 0 0 0",
                     sif.in_ready, sif.validdatac, sif.dataa, sif.datac, sif.result_id, sif.busy);
        end
    endtask

    task automatic test_single();
        int k;
        bit seen;
        tick();
        sif.issue_en = 1'b1;
        sif.in_a     = 32'h4040_0000;   // 3.0
        sif.in_b     = 32'h3FC0_0000;   // 1.5
        sif.in_c     = 32'h4000_0000;   // 2.0
        sif.in_valid = 1'b1;
        @(negedge clock);
        n_checks++;
        if (sif.in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL single_ready: got %b expected 1", sif.in_ready);
        end
        tick();
        sif.in_valid = 1'b0;
        k = 1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (sif.validdataa) begin
                seen = 1'b1;
                break;
            end
            k++;
        end
        n_checks++;
        if (!seen || k != 2) begin
            n_errors++;
            $display("FAIL single_ab_latency: got %0d (seen=%b) expected 2", k, seen);
        end
        n_checks++;
        if (sif.busy !== 1'b1) begin
            n_errors++;
            $display("FAIL single_busy: got %b expected 1", sif.busy);
        end
        k = 0;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            k++;
            if (sif.validdatac) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!seen || k != C_DLY || sif.datac !== 32'h4000_0000) begin
            n_errors++;
            $display("FAIL single_c_latency: got %0d c=%h expected %0d c=40000000", k, sif.datac, C_DLY);
        end
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            k++;
            if (sif.result_valid) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!seen || k != RES_LAT || sif.result_id !== 8'd0) begin
            n_errors++;
            $display("FAIL single_result: got lat=%0d id=%0d expected lat=%0d id=0", k, sif.result_id, RES_LAT);
        end
        wait_idle();
    endtask

    task automatic test_fill();
        logic [7:0] vec;
        bit acc = 1'b0;
        sif.issue_en = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive_one($urandom, $urandom, $urandom);
        end
        sif.in_a = $urandom;
        sif.in_b = $urandom;
        sif.in_c = $urandom;
        @(negedge clock);
        n_checks++;
        if (sif.in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL fill_full: in_ready got %b expected 0", sif.in_ready);
        end
        tick();
        @(negedge clock);
        n_checks++;
        if (sif.in_ready !== 1'b0 || sif.validdataa !== 1'b0) begin
            n_errors++;
            $display("FAIL fill_hold: got rdy=%b va=%b expected 0 0", sif.in_ready, sif.validdataa);
        end
        tick();
        sif.issue_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            vec[i] = sif.validdataa;
            if (sif.in_valid && sif.in_ready) acc = 1'b1;
            tick();
            if (acc) sif.in_valid = 1'b0;
        end
        n_checks++;
        if (vec !== 8'b0011_1110 || !acc) begin
            n_errors++;
            $display("FAIL fill_drain: issue pattern got %b acc=%b expected 00111110 acc=1", vec, acc);
        end
        wait_idle();
    endtask

    task automatic test_pause();
        logic [7:0] vec;
        sif.issue_en = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive_one($urandom, $urandom, $urandom);
        end
        sif.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sif.issue_en = (i % 2 == 0);
            @(negedge clock);
            vec[i] = sif.validdataa;
            tick();
        end
        sif.issue_en = 1'b1;
        n_checks++;
        if (vec !== 8'b1010_1010) begin
            n_errors++;
            $display("FAIL pause_pattern: issue pattern got %b expected 10101010", vec);
        end
        wait_idle();
    endtask

    task automatic test_id_wrap();
        int base;
        sif.issue_en = 1'b1;
        do_reset();
        base = res_seen;
        for (int i = 0; i < 260; i++) begin
            drive_one($urandom, $urandom, $urandom);
        end
        sif.in_valid = 1'b0;
        wait_idle();
        n_checks++;
        if (res_seen - base != 260 || last_res_id !== 8'd3) begin
            n_errors++;
            $display("FAIL id_wrap: got %0d results last id %0d expected 260 results last id 3",
                     res_seen - base, last_res_id);
        end
    endtask

    task automatic test_reset_mid();
        int  cnt = 0;
        bit  seen = 1'b0;
        sif.issue_en = 1'b1;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive_one($urandom, $urandom, $urandom);
        end
        sif.in_valid = 1'b0;
        repeat (6) tick();
        resetn = 1'b0;
        repeat (2) tick();
        resetn = 1'b1;
        @(negedge clock);
        n_checks++;
        if (sif.busy !== 1'b0 || sif.in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL midreset_release: got busy=%b rdy=%b expected 0 1", sif.busy, sif.in_ready);
        end
        for (int i = 0; i < 70; i++) begin
            @(negedge clock);
            if (sif.result_valid) cnt++;
        end
        n_checks++;
        if (cnt != 0) begin
            n_errors++;
            $display("FAIL midreset_ghost: result_valid pulses got %0d expected 0", cnt);
        end
        tick();
        drive_one(32'h4040_0000, 32'h3FC0_0000, 32'h4000_0000);
        sif.in_valid = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clock);
            if (sif.result_valid) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!seen || sif.result_id !== 8'd0) begin
            n_errors++;
            $display("FAIL midreset_next_id: got seen=%b id=%0d expected seen=1 id=0", seen, sif.result_id);
        end
        wait_idle();
    endtask

    initial begin
        sif.in_valid = 1'b0;
        sif.in_a     = '0;
        sif.in_b     = '0;
        sif.in_c     = '0;
        sif.issue_en = 1'b0;
        fork
            scoreboard_monitor();
        join_none
        test_reset();
        test_single();
        test_fill();
        test_pause();
        test_id_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
